// File: rtl/freelist.sv
// Physical-register free list: circular buffer of free prd indices, 4-wide allocate and 4-wide release.
// Self-initialises after reset with p(NARCH)..p(NPREG-1); p0 is never accepted back.
module freelist #(
    parameter int WIDTH_REG = 7,
    parameter int NARCH     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [4*WIDTH_REG-1:0] o_alloc_prd4x,
    output logic                   o_alloc_ready,
    input  logic [3:0]             i_alloc_mask,
    input  logic                   i_alloc_we,
    input  logic [4*WIDTH_REG-1:0] i_com_prd4x,
    input  logic [3:0]             i_com_mask,
    input  logic                   i_com_en,
    output logic [WIDTH_REG:0]     o_count,
    output logic                   o_init_done,
    output logic                   o_err
);

    localparam int NPREG = 1 << WIDTH_REG;
    localparam int NFREE = NPREG - NARCH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 r_state;
    logic [WIDTH_REG-1:0]   r_head;
    logic [WIDTH_REG-1:0]   r_tail;
    logic [WIDTH_REG-1:0]   r_init_cnt;
    logic [WIDTH_REG:0]     r_count;
    logic                   r_err;
    logic [WIDTH_REG-1:0]   r_mem [NPREG];

    logic                   w_run;
    logic                   w_ready;
    logic                   w_alloc;
    logic [2:0]             w_nalloc;
    logic [2:0]             w_nfree;
    logic [3:0]             w_fvld;
    logic [WIDTH_REG-1:0]   w_com_prd [4];
    logic [WIDTH_REG-1:0]   w_widx [4];
    logic [4*WIDTH_REG-1:0] w_alloc_prd4x;
    logic [WIDTH_REG+1:0]   w_count_nx;
    logic                   w_ovf;

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    assign w_run    = (r_state == S_RUN);
    assign w_ready  = w_run && (r_count >= (WIDTH_REG+1)'(4));
    assign w_alloc  = i_alloc_we & w_ready;
    assign w_nalloc = w_alloc ? popcnt4(i_alloc_mask) : 3'd0;

    // Free lanes are compacted in lane order; the running offset gives each lane its write slot.
    always_comb begin
        logic [WIDTH_REG-1:0] off;
        off = '0;
        for (int k = 0; k < 4; k++) begin
            w_com_prd[k] = i_com_prd4x[k*WIDTH_REG +: WIDTH_REG];
            w_fvld[k]    = w_run & i_com_en & i_com_mask[k] & (w_com_prd[k] != '0);
            w_widx[k]    = r_tail + off;
            if (w_fvld[k]) off = off + 1'b1;
        end
    end

    assign w_nfree    = popcnt4(w_fvld);
    assign w_count_nx = {1'b0, r_count} + (WIDTH_REG+2)'(w_nfree) - (WIDTH_REG+2)'(w_nalloc);
    assign w_ovf      = w_count_nx > (WIDTH_REG+2)'(NFREE);

    // Zero-latency read: lane k takes the entry after the lower requesting lanes.
    always_comb begin
        logic [WIDTH_REG-1:0] off;
        off           = '0;
        w_alloc_prd4x = '0;
        for (int k = 0; k < 4; k++) begin
            if (i_alloc_mask[k]) begin
                w_alloc_prd4x[k*WIDTH_REG +: WIDTH_REG] = r_mem[r_head + off];
                off = off + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_INIT;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_init_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_tail     <= r_tail + 1'b1;
                    r_count    <= r_count + 1'b1;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == WIDTH_REG'(NFREE - 1)) r_state <= S_RUN;
                end
                default: begin
                    r_head  <= r_head + WIDTH_REG'(w_nalloc);
                    r_tail  <= r_tail + WIDTH_REG'(w_nfree);
                    r_count <= w_count_nx[WIDTH_REG:0];
                    if (w_ovf) r_err <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_tail] <= WIDTH_REG'(NARCH) + r_init_cnt;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_fvld[k]) r_mem[w_widx[k]] <= w_com_prd[k];
            end
        end
    end

    assign o_alloc_prd4x = i_rst ? '0 : w_alloc_prd4x;
    assign o_alloc_ready = ~i_rst & w_ready;
    assign o_count       = i_rst ? '0 : r_count;
    assign o_init_done   = ~i_rst & w_run;
    assign o_err         = ~i_rst & r_err;

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: stimulus queues expected prd values, a negedge monitor pops and compares.
module tb_freelist;

    localparam int W = 7;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [4*W-1:0] o_alloc_prd4x;
    logic           o_alloc_ready;
    logic [3:0]     i_alloc_mask;
    logic           i_alloc_we;
    logic [4*W-1:0] i_com_prd4x;
    logic [3:0]     i_com_mask;
    logic           i_com_en;
    logic [W:0]     o_count;
    logic           o_init_done;
    logic           o_err;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    freelist #(.WIDTH_REG(W), .NARCH(32)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_alloc_prd4x(o_alloc_prd4x), .o_alloc_ready(o_alloc_ready),
        .i_alloc_mask(i_alloc_mask), .i_alloc_we(i_alloc_we),
        .i_com_prd4x(i_com_prd4x), .i_com_mask(i_com_mask), .i_com_en(i_com_en),
        .o_count(o_count), .o_init_done(o_init_done), .o_err(o_err)
    );

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [4*W-1:0] pack4(input int l3, input int l2, input int l1, input int l0);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    task automatic step(input logic awe, input logic [3:0] am, input logic cen,
                        input logic [3:0] cm, input logic [4*W-1:0] cp);
        i_alloc_we = awe; i_alloc_mask = am;
        i_com_en = cen; i_com_mask = cm; i_com_prd4x = cp;
        @(posedge clk); #1;
        i_alloc_we = 1'b0; i_alloc_mask = '0;
        i_com_en = 1'b0; i_com_mask = '0; i_com_prd4x = '0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (o_init_done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(W'(a)); exp_q.push_back(W'(b));
        exp_q.push_back(W'(c)); exp_q.push_back(W'(d));
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] act;
        if (!i_rst && i_alloc_we && o_alloc_ready) begin
            for (int k = 0; k < 4; k++) begin
                act = o_alloc_prd4x[k*W +: W];
                if (i_alloc_mask[k]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL alloc_lane%0d: got %0d with no expected value queued", k, act);
                    end else begin
                        chk($sformatf("alloc_lane%0d", k), int'(act), int'(exp_q.pop_front()));
                    end
                end else begin
                    chk($sformatf("idle_lane%0d", k), int'(act), 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int f[4];
        i_rst = 1'b1; i_alloc_we = 1'b0; i_alloc_mask = '0;
        i_com_en = 1'b0; i_com_mask = '0; i_com_prd4x = '0;
        #1;
        chk("rst_count", int'(o_count), 0);
        chk("rst_init_done", int'(o_init_done), 0);
        chk("rst_ready", int'(o_alloc_ready), 0);
        chk("rst_err", int'(o_err), 0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        wait_init(n);
        chk("init_cycles", n, 96);
        chk("init_count", int'(o_count), 96);
        chk("init_ready", int'(o_alloc_ready), 1);
        chk("init_err", int'(o_err), 0);

        push4(32, 33, 34, 35);
        step(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
        chk("count_after_alloc4", int'(o_count), 92);
        exp_q.push_back(W'(36)); exp_q.push_back(W'(37));
        step(1'b1, 4'b1010, 1'b0, 4'b0000, '0);
        chk("count_after_alloc2", int'(o_count), 90);

        step(1'b0, 4'b0000, 1'b1, 4'b1111, pack4(7, 6, 5, 0));
        chk("count_after_free_p0", int'(o_count), 93);

        for (int i = 0; i < 22; i++) begin
            push4(38 + 4*i, 39 + 4*i, 40 + 4*i, 41 + 4*i);
            step(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
        end
        chk("count_drain", int'(o_count), 5);
        exp_q.push_back(W'(126)); exp_q.push_back(W'(127));
        step(1'b1, 4'b0011, 1'b0, 4'b0000, '0);
        chk("count_at_3", int'(o_count), 3);
        chk("ready_at_3", int'(o_alloc_ready), 0);

        step(1'b1, 4'b1111, 1'b1, 4'b0011, pack4(0, 0, 11, 10));
        chk("count_ignored_alloc", int'(o_count), 5);
        chk("ready_at_5", int'(o_alloc_ready), 1);
        push4(5, 6, 7, 10);
        step(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
        chk("count_after_recycled", int'(o_count), 1);

        mq.push_back(W'(11));
        step(1'b0, 4'b0000, 1'b1, 4'b0111, pack4(0, 14, 13, 12));
        mq.push_back(W'(12)); mq.push_back(W'(13)); mq.push_back(W'(14));
        chk("count_pre_steady", int'(o_count), 4);
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) begin
                f[k] = ((i*4 + k) % 120) + 1;
                exp_q.push_back(mq.pop_front());
            end
            step(1'b1, 4'b1111, 1'b1, 4'b1111, pack4(f[3], f[2], f[1], f[0]));
            for (int k = 0; k < 4; k++) mq.push_back(W'(f[k]));
            chk($sformatf("steady_count_%0d", i), int'(o_count), 4);
        end

        for (int i = 0; i < 23; i++) begin
            step(1'b0, 4'b0000, 1'b1, 4'b1111, pack4(60, 61, 62, 63));
        end
        chk("count_full", int'(o_count), 96);
        chk("err_at_full", int'(o_err), 0);
        step(1'b0, 4'b0000, 1'b1, 4'b0001, pack4(0, 0, 0, 9));
        chk("count_overflow", int'(o_count), 97);
        chk("err_set", int'(o_err), 1);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, '0);
        chk("err_sticky", int'(o_err), 1);

        i_rst = 1'b1; i_alloc_we = 1'b1; i_alloc_mask = 4'b1111;
        i_com_en = 1'b1; i_com_mask = 4'b1111; i_com_prd4x = pack4(20, 21, 22, 23);
        #1;
        chk("midrst_err", int'(o_err), 0);
        chk("midrst_count", int'(o_count), 0);
        chk("midrst_init_done", int'(o_init_done), 0);
        @(posedge clk); #1;
        i_rst = 1'b0; i_alloc_we = 1'b0; i_alloc_mask = '0;
        i_com_en = 1'b0; i_com_mask = '0; i_com_prd4x = '0;
        wait_init(n);
        chk("reinit_cycles", n, 96);
        chk("reinit_count", int'(o_count), 96);
        chk("reinit_err", int'(o_err), 0);
        push4(32, 33, 34, 35);
        step(1'b1, 4'b1111, 1'b0, 4'b0000, '0);
        chk("reinit_count_after_alloc", int'(o_count), 92);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
